// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and op classification for multicycle_alu.
// Honours MULTICYCLE_ALU_DIV_EN: when undefined, only MUL counts as multi-cycle.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_MUL  = 4'd8;
    localparam logic [3:0] ALU_DIVU = 4'd9;
    localparam logic [3:0] ALU_REMU = 4'd10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} aluState_t;

    // Divide-by-zero is still single-cycle; the caller filters that case on B.
    function automatic logic isMultiCycle(input logic [3:0] op);
`ifdef MULTICYCLE_ALU_DIV_EN
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
`else
        return (op == ALU_MUL);
`endif
    endfunction

endpackage

// File: rtl/iter_muldiv.sv
// N-iteration shift-add multiplier and restoring divider sharing one set of registers.
// The divider datapath exists only when MULTICYCLE_ALU_DIV_EN is defined.
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         done,
    output logic [N-1:0] result
);

    logic [CNT_W-1:0] count;
    logic [N-1:0]     regA;
    logic [N-1:0]     regB;
    logic [N-1:0]     acc;
    logic [N-1:0]     mulSum;

    // regA shifts the multiplicand left while regB shifts the multiplier right.
    assign mulSum = acc + (regB[0] ? regA : '0);
    assign done   = (count == CNT_W'(1));

`ifdef MULTICYCLE_ALU_DIV_EN
    logic         isDiv;
    logic         wantRem;
    logic [N:0]   shifted;
    logic [N:0]   trial;
    logic         fits;
    logic [N-1:0] remNext;
    logic [N-1:0] quoNext;

    // For division acc is the partial remainder and regA shifts the dividend out as quotient bits shift in.
    assign shifted = {acc, regA[N-1]};
    assign trial   = shifted - {1'b0, regB};
    assign fits    = ~trial[N];
    assign remNext = fits ? trial[N-1:0] : shifted[N-1:0];
    assign quoNext = {regA[N-2:0], fits};
    assign result  = !isDiv ? mulSum : (wantRem ? remNext : quoNext);
`else
    logic unusedOp;
    assign unusedOp = ^op;
    assign result   = mulSum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            regA    <= '0;
            regB    <= '0;
            acc     <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
            isDiv   <= 1'b0;
            wantRem <= 1'b0;
`endif
        end else if (start) begin
            count   <= CNT_W'(N);
            regA    <= a;
            regB    <= b;
            acc     <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
            isDiv   <= (op != ALU_MUL);
            wantRem <= (op == ALU_REMU);
`endif
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
`ifdef MULTICYCLE_ALU_DIV_EN
            if (isDiv) begin
                acc  <= remNext;
                regA <= quoNext;
            end else begin
                acc  <= mulSum;
                regA <= regA << 1;
                regB <= regB >> 1;
            end
`else
            acc  <= mulSum;
            regA <= regA << 1;
            regB <= regB >> 1;
`endif
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked ALU: single-cycle logic/add ops plus iterative MUL (and DIVU/REMU
// when MULTICYCLE_ALU_DIV_EN is defined), with a registered result and zero flag.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int N = 32,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         ZFlag
);

    aluState_t    state;
    aluState_t    nextState;
    logic         accept;
    logic         isMulti;
    logic         mdDone;
    logic [N-1:0] mdResult;
    logic [N-1:0] singleResult;
    logic         doSub;
    logic [N-1:0] sum;
    logic         slt;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign ZFlag     = (out == '0);

`ifdef MULTICYCLE_ALU_DIV_EN
    assign isMulti = isMultiCycle(sel) && !(((sel == ALU_DIVU) || (sel == ALU_REMU)) && (B == '0));
`else
    assign isMulti = isMultiCycle(sel);
`endif

    // One adder serves ADD, SUB and SLT; SLT falls back to the sign of A-B only when signs agree.
    assign doSub = (sel == ALU_SUB) || (sel == ALU_SLT);
    assign sum   = A + (doSub ? ~B : B) + {{(N-1){1'b0}}, doSub};
    assign slt   = (A[N-1] != B[N-1]) ? A[N-1] : sum[N-1];

    always_comb begin
        singleResult = '0;
        case (sel)
            ALU_AND:  singleResult = A & B;
            ALU_OR:   singleResult = A | B;
            ALU_ADD:  singleResult = sum;
            ALU_XOR:  singleResult = A ^ B;
            ALU_SUB:  singleResult = sum;
            ALU_SLT:  singleResult = {{(N-1){1'b0}}, slt};
`ifdef MULTICYCLE_ALU_DIV_EN
            ALU_DIVU: singleResult = '1;
            ALU_REMU: singleResult = A;
`endif
            default:  singleResult = '0;
        endcase
    end

    iter_muldiv #(.N(N), .CNT_W(CNT_W)) muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && isMulti),
        .op     (sel),
        .a      (A),
        .b      (B),
        .done   (mdDone),
        .result (mdResult)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // DONE with out_ready doubles as IDLE so back-to-back single-cycle ops run at one per clock.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = isMulti ? BUSY : DONE;
            BUSY:    if (mdDone) nextState = DONE;
            DONE:    if (out_ready) nextState = in_valid ? (isMulti ? BUSY : DONE) : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          out <= '0;
        else if (accept && !isMulti)      out <= singleResult;
        else if (state == BUSY && mdDone) out <= mdResult;
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomised self-checking bench for multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, ZFlag;
    logic [3:0]   sel;
    logic [N-1:0] A, B, out;

    int assertCount = 0;
    int failCount   = 0;

    multicycle_alu #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .ZFlag(ZFlag)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] refResult(input logic [3:0] s, input logic [N-1:0] a, input logic [N-1:0] b);
        case (s)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return a + b;
            4'd3: return a ^ b;
            4'd6: return a - b;
            4'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8: return a * b;
`ifdef MULTICYCLE_ALU_DIV_EN
            4'd9:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd10: return (b == 0) ? a : a % b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Edges between the accept edge and the edge after which out_valid is high.
    function automatic int refEdges(input logic [3:0] s, input logic [N-1:0] b);
        if (s == 4'd8) return N;
`ifdef MULTICYCLE_ALU_DIV_EN
        if ((s == 4'd9 || s == 4'd10) && b != 0) return N;
`endif
        return 0;
    endfunction

    // Drives one op with out_ready low, scrambles inputs while waiting, reports elapsed edges.
    task automatic runOp(input logic [3:0] s, input logic [N-1:0] a, input logic [N-1:0] b,
                         output int edges, output logic readyLeak);
        @(negedge clk);
        in_valid = 1'b1; sel = s; A = a; B = b; out_ready = 1'b0;
        @(posedge clk); #1;
        edges = 0; readyLeak = 1'b0;
        A = $urandom; B = $urandom; sel = 4'($urandom);
        while (!out_valid && edges < N + 8) begin
            if (in_ready) readyLeak = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; sel = '0;
        #1 rst = 1'b1;
        #2;
        assertCount++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        assertCount++; if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        assertCount++; if (out !== '0) begin failCount++; $display("[TB] FAIL reset_out: got %h expected 0", out); end
        assertCount++; if (ZFlag !== 1'b1) begin failCount++; $display("[TB] FAIL reset_zflag: got %b expected 1", ZFlag); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0]   codes [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        logic [3:0]   s;
        logic [N-1:0] a, b, exp;
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 0)      begin s = 4'd2; a = 32'h7FFF_FFFF; b = 32'd1; end
            else if (i == 1) begin s = 4'd6; a = 32'd5; b = 32'd5; end
            else if (i == 2) begin s = 4'd7; a = 32'hFFFF_FFFF; b = 32'd1; end
            else begin s = codes[$urandom_range(0, 12)]; a = $urandom; b = $urandom; end
            exp = refResult(s, a, b);
            @(negedge clk);
            assertCount++; if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL single_in_ready: got %b expected 1", in_ready); end
            in_valid = 1'b1; sel = s; A = a; B = b;
            @(posedge clk); #1;
            assertCount++; if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL single_valid sel=%0d: got %b expected 1", s, out_valid); end
            assertCount++; if (out !== exp) begin failCount++; $display("[TB] FAIL single_out sel=%0d: got %h expected %h", s, out, exp); end
            assertCount++; if (ZFlag !== (exp == 0)) begin failCount++; $display("[TB] FAIL single_zflag sel=%0d: got %b expected %b", s, ZFlag, exp == 0); end
        end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        assertCount++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL single_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   s;
        logic [N-1:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            assertCount++; if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_in_ready cycle %0d: got %b expected 1", i, in_ready); end
            s = (i % 3 == 2) ? 4'd3 : 4'(i % 3);
            in_valid = 1'b1; sel = s; A = $urandom; B = $urandom;
            exp = refResult(s, A, B);
            @(posedge clk); #1;
            assertCount++; if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_valid cycle %0d: got %b expected 1", i, out_valid); end
            assertCount++; if (out !== exp) begin failCount++; $display("[TB] FAIL b2b_out cycle %0d: got %h expected %h", i, out, exp); end
        end
        consume();
    endtask

    task automatic test_mul();
        logic [N-1:0] a, b, exp;
        int           edges;
        logic         leak;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin a = 32'h0001_0003; b = 32'd5; end
            else begin a = $urandom; b = (i == 3) ? 32'd0 : $urandom; end
            exp = refResult(4'd8, a, b);
            runOp(4'd8, a, b, edges, leak);
            assertCount++; if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL mul_timeout: out_valid %b after %0d edges, expected 1", out_valid, edges); end
            assertCount++; if (edges != refEdges(4'd8, b)) begin failCount++; $display("[TB] FAIL mul_latency: got %0d edges expected %0d", edges, refEdges(4'd8, b)); end
            assertCount++; if (out !== exp) begin failCount++; $display("[TB] FAIL mul_out: got %h expected %h", out, exp); end
            assertCount++; if (ZFlag !== (exp == 0)) begin failCount++; $display("[TB] FAIL mul_zflag: got %b expected %b", ZFlag, exp == 0); end
            assertCount++; if (leak !== 1'b0) begin failCount++; $display("[TB] FAIL mul_busy_ready: in_ready seen %b during busy, expected 0", leak); end
            consume();
            assertCount++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL mul_consume: got %b expected 0", out_valid); end
        end
    endtask

    // Expected results and latencies come from the model, so this covers both builds.
    task automatic test_div();
        logic [3:0]   s;
        logic [N-1:0] a, b, exp;
        int           edges;
        logic         leak;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin s = 4'd9;  a = 32'd100; b = 32'd7; end
                1: begin s = 4'd10; a = 32'd100; b = 32'd7; end
                2: begin s = 4'd9;  a = $urandom; b = 32'd0; end
                3: begin s = 4'd10; a = 32'd9;   b = 32'd0; end
                default: begin s = 4'(9 + (i % 2)); a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            exp = refResult(s, a, b);
            runOp(s, a, b, edges, leak);
            assertCount++; if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL div_timeout sel=%0d: out_valid %b after %0d edges", s, out_valid, edges); end
            assertCount++; if (edges != refEdges(s, b)) begin failCount++; $display("[TB] FAIL div_latency sel=%0d: got %0d edges expected %0d", s, edges, refEdges(s, b)); end
            assertCount++; if (out !== exp) begin failCount++; $display("[TB] FAIL div_out sel=%0d %h/%h: got %h expected %h", s, a, b, out, exp); end
            assertCount++; if (ZFlag !== (exp == 0)) begin failCount++; $display("[TB] FAIL div_zflag sel=%0d: got %b expected %b", s, ZFlag, exp == 0); end
            assertCount++; if (leak !== 1'b0) begin failCount++; $display("[TB] FAIL div_busy_ready sel=%0d: in_ready seen %b, expected 0", s, leak); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] a, b, exp;
        int           edges;
        logic         leak;
        a = $urandom | 32'd1; b = $urandom | 32'd1;
        exp = refResult(4'd8, a, b);
        runOp(4'd8, a, b, edges, leak);
        assertCount++; if (out !== exp) begin failCount++; $display("[TB] FAIL bp_result: got %h expected %h", out, exp); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            assertCount++; if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL bp_valid cycle %0d: got %b expected 1", i, out_valid); end
            assertCount++; if (out !== exp) begin failCount++; $display("[TB] FAIL bp_out cycle %0d: got %h expected %h", i, out, exp); end
            assertCount++; if (ZFlag !== (exp == 0)) begin failCount++; $display("[TB] FAIL bp_zflag cycle %0d: got %b expected %b", i, ZFlag, exp == 0); end
            assertCount++; if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL bp_in_ready cycle %0d: got %b expected 0", i, in_ready); end
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0;
        #1;
        assertCount++; if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL bp_release_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        assertCount++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL bp_consume: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        in_valid = 1'b1; sel = 4'd8; A = $urandom | 32'd3; B = $urandom | 32'd5; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        assertCount++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_valid: got %b expected 0", out_valid); end
        assertCount++; if (out !== '0) begin failCount++; $display("[TB] FAIL midrst_out: got %h expected 0", out); end
        assertCount++; if (ZFlag !== 1'b1) begin failCount++; $display("[TB] FAIL midrst_zflag: got %b expected 1", ZFlag); end
        assertCount++; if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready); end
        @(negedge clk); rst = 1'b0;
        repeat (N + 2) @(posedge clk);
        #1;
        assertCount++; if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_no_result: got %b expected 0", out_valid); end
        @(negedge clk);
        in_valid = 1'b1; sel = 4'd2; A = 32'd2; B = 32'd3;
        @(posedge clk); #1;
        assertCount++; if (out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL midrst_add_valid: got %b expected 1", out_valid); end
        assertCount++; if (out !== 32'd5) begin failCount++; $display("[TB] FAIL midrst_add_out: got %h expected 5", out); end
        consume();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised successor to the single-cycle datapath ALU: the same AND/OR/ADD/SUB core extended with XOR and SLT, plus iterative unsigned multiply, divide and remainder. The result and zero flag are registered, and operations are exchanged through valid/ready handshakes. It sits between the decode/operand stage and writeback. The core stalls on `in_ready` while a multi-cycle operation is in flight.

## Interface
- `N`, 32: operand/result width, ≥ 4.
- `CNT_W`, $clog2(N+1): iteration counter width (derived; do not override).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operands and `sel` valid.
- `in_ready` output 1: block can accept an operation this cycle.
- `A` input N: operand A.
- `B` input N: operand B.
- `sel` input 4: operation select.
- `out_valid` output 1: `out` and `ZFlag` hold a completed result.
- `out_ready` input 1: consumer takes the result.
- `out` output N: registered result.
- `ZFlag` output 1: `out == 0`, derived from the result register.

## Operation
- `sel` encoding:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 6 SUB (A + ~B + 1), 7 SLT (signed, result 0 or 1).
  - 8 MUL (low N bits of A*B), 9 DIVU, 10 REMU.
  - All other codes produce 0.
- All arithmetic wraps modulo 2^N. No carry or overflow outputs.
- Single-cycle ops (0–7, undefined codes, divide-by-zero): the result is registered on the accept edge.
- MUL: shift-add, one partial product per cycle, N iterations.
- DIVU/REMU: restoring division, one quotient bit per cycle, N iterations.
  - B == 0 is resolved in a single cycle.
  - DIVU gives all-ones.
  - REMU gives A.
- State machine:
  - IDLE: `in_ready`=1. An accept of a single-cycle op goes to DONE. An accept of op 8/9/10 (B≠0 for 9/10) goes to BUSY with counter=N.
  - BUSY: `in_ready`=0. One iteration per edge, counter decrements. At counter==1 the final iteration writes `out` and the state goes to DONE.
  - DONE: `out_valid`=1 and `in_ready`=`out_ready`.
    - `out_ready`=1 and `in_valid`=0: go to IDLE.
    - `out_ready`=1 and `in_valid`=1: accept the new op in the same cycle (next state per the IDLE rules). This gives back-to-back single-cycle throughput of 1 per clock.
    - `out_ready`=0: hold `out` and `ZFlag` stable.
- Operands are latched on accept. `A`, `B` and `sel` may change afterwards.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `out`=0, `ZFlag`=1, counter 0, internal operand registers 0.
- Accept occurs on a rising edge where `in_valid && in_ready`.
- Single-cycle op accepted at edge k: `out_valid` is high after edge k.
- MUL/DIVU/REMU accepted at edge k: `out_valid` rises after edge k+N. `in_ready` is low for N cycles.
- A result is consumed on an edge where `out_valid && out_ready`.
- Reset asserted mid-BUSY or in DONE: the operation is abandoned, outputs take their reset values immediately, and no result is produced.
- `in_valid` while BUSY is ignored and must be held by the source.
- `ZFlag` always reflects the current `out` register, including while holding in DONE.

## Configuration
- `MULTICYCLE_ALU_DIV_EN` defined:
  - DIVU/REMU implemented as above.
  - Divider datapath (N-bit remainder register plus subtractor) present.
- `MULTICYCLE_ALU_DIV_EN` undefined:
  - `sel` 9 and 10 behave as undefined codes: single-cycle, result 0, `ZFlag`=1.
  - No divider logic is synthesised.
  - MUL is unaffected.

## Structure
- Shared package `alu_pkg`:
  - Op-code localparams `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_XOR`, `ALU_SUB`, `ALU_SLT`, `ALU_MUL`, `ALU_DIVU`, `ALU_REMU`.
  - FSM state enum {IDLE, BUSY, DONE}.
  - A function flagging multi-cycle op codes.
- Sub-module `iter_muldiv`:
  - Holds the N-iteration shift-add/restoring-divide datapath and counter.
  - Ports: start, op, operands, done, result.
- Top level keeps the handshake FSM, the single-cycle ops and the result register. It reuses the existing adder for ADD/SUB/SLT.

## Test plan
- Reset then single ops with N=32, `out_ready`=1:
  - ADD 0x7FFFFFFF+1 gives 0x80000000, 1 cycle latency.
  - SUB 5−5 gives 0 with `ZFlag`=1.
  - SLT 0xFFFFFFFF,1 gives 1.
- Back-to-back AND/OR/XOR on consecutive cycles, `in_valid` held high: one result per clock, `in_ready` never drops.
- MUL 0x0001_0003 × 0x0000_0005 gives 0x0005_000F.
  - `out_valid` rises exactly 32 edges after accept.
  - `in_ready`=0 throughout BUSY.
  - A new `in_valid` during BUSY is not accepted.
- With `MULTICYCLE_ALU_DIV_EN` defined:
  - DIVU 100/7 gives 14 and REMU gives 2, 32-cycle latency.
  - DIVU x/0 gives 0xFFFFFFFF and REMU 9/0 gives 9, 1-cycle latency.
  - Without the macro, DIVU 100/7 gives 0 with `ZFlag`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after a MUL result. `out`, `ZFlag` and `out_valid` stay stable, and `in_ready`=0 until `out_ready` rises.
- Assert `rst` 10 cycles into a MUL: `out_valid`=0, `out`=0 and `ZFlag`=1 immediately (asynchronously). Then a fresh ADD 2+3 returns 5.
